ctrl_pipe_regs: RTL
===================

Name: ctrl_pipe_regs

Overview:
Control-signal pipeline for the 64-bit pipelined core. It sits directly downstream of the main control unit in ID. It captures the decoded control bundle and carries it through the EX, MEM and WB stage registers. It replaces ad-hoc per-bit delay flops with one block that handles load-use bubbles, branch flushes and global freeze. It also keeps saturating hazard counters for debug.

Parameters:
EX_W, 4, width of EX-only controls (ALUSrc, ALUOp[1:0], SetFlags)
MEM_W, 3, width of MEM-only controls (MemRead, MemWrite, Branch)
WB_W, 2, width of WB-only controls (RegWrite, MemToReg)
CNT_W, 8, width of the bubble and flush counters

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
id_ex_ctrl  in  EX_W  EX controls from the control unit
id_mem_ctrl  in  MEM_W  MEM controls from the control unit
id_wb_ctrl  in  WB_W  WB controls from the control unit
id_valid  in  1  ID holds a real instruction
bubble  in  1  load-use hazard: insert a NOP into EX
flush  in  1  taken branch: kill the instructions entering EX and MEM
freeze  in  1  global stall: all stages hold
ex_ex_ctrl  out  EX_W  EX-stage controls
ex_mem_ctrl  out  MEM_W  MEM controls riding in EX
ex_wb_ctrl  out  WB_W  WB controls riding in EX
ex_valid  out  1  EX stage valid
mem_mem_ctrl  out  MEM_W  MEM-stage controls
mem_wb_ctrl  out  WB_W  WB controls riding in MEM
mem_valid  out  1  MEM stage valid
wb_wb_ctrl  out  WB_W  WB-stage controls
wb_valid  out  1  WB stage valid
bubble_cnt  out  CNT_W  bubbles inserted, saturating
flush_cnt  out  CNT_W  flushes applied, saturating

Behaviour:
- All registers update on posedge clk only. Every output is registered; no combinational input-to-output path.
- Reset (synchronous, active-high): every output is 0, including the counters. Reset overrides all other inputs. A reset asserted mid-stream clears all in-flight entries at that edge.
- Priority at each edge: reset > freeze > flush > bubble > normal advance.
- Freeze: every stage register and both counters hold. A flush or bubble asserted during freeze is ignored. The hazard unit keeps it asserted until freeze drops.
- Normal advance:
  - EX <= {id_*_ctrl, id_valid}
  - MEM <= {ex_mem_ctrl, ex_wb_ctrl, ex_valid}
  - WB <= {mem_wb_ctrl, mem_valid}
- Bubble (no flush): EX loads all-zero controls with ex_valid=0. MEM and WB advance normally. bubble_cnt increments.
- Flush: EX and MEM both load zeros with valid=0. WB advances normally, so the instruction already in MEM retires. flush_cnt increments. If bubble is also high, only flush_cnt counts.
- Invalid entries: whenever a stage's valid is 0, all of its control fields are 0. id_valid=0 with nonzero id controls still loads zeros into EX.
- Latency: a bundle captured at edge N appears on the ex_* outputs after N, mem_* after N+1 and wb_wb_ctrl after N+2. That is three clock edges from ID sample to WB use, each freeze cycle adding one.
- Counters: saturate at 2^CNT_W-1 and do not wrap.
- Implementation size: roughly 150–250 lines of RTL.

Test Plan:
- Reset, then hold reset 2 cycles -> all outputs 0. id_valid=1, id_wb_ctrl=2'b11 held during reset -> still 0 after release edge until the next capture.
- Stream three bundles A (ex=4'hA, mem=3'b101, wb=2'b01), B (4'h5, 3'b010, 2'b10), C (4'hF, 3'b111, 2'b11), one per cycle -> ex_ex_ctrl A,B,C on consecutive cycles; wb_wb_ctrl 01,10,11 appearing exactly 2 cycles after the matching ex_* values; valids track.
- Bubble one cycle with B at ID -> ex_* = 0 and ex_valid=0 for one cycle while A advances to MEM; bubble_cnt=1.
- Flush with A in MEM, B in EX, C at ID -> next cycle ex/mem zero with valid=0, wb_wb_ctrl=A's 01 with wb_valid=1; flush_cnt=1. Same test with bubble also high -> bubble_cnt unchanged.
- Freeze 3 cycles with A/B/C in flight, flush pulsed during freeze -> all outputs constant, counters unchanged; after release, advance resumes with no loss.
- CNT_W=2, 5 bubbles -> bubble_cnt sticks at 3. Reset mid-stream -> everything 0 on the following edge.

Source files
------------

// File: rtl/ctrl_pipe_regs_if.sv
// ctrl_pipe_regs_if
// Purpose: groups the control-pipeline connections into one bundle.
//   The master side is the control unit / hazard unit (drives ID controls
//   and hazard requests). The slave side is the pipeline register block
//   (returns the EX/MEM/WB stage controls and the debug counters).
// Signals:
//   id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_valid : decoded bundle at ID
//   bubble, flush, freeze                         : hazard requests
//   ex_*, mem_*, wb_*                             : per-stage controls/valids
//   bubble_cnt, flush_cnt                         : saturating hazard counters
interface ctrl_pipe_regs_if #(
  parameter int EX_W  = 4,
  parameter int MEM_W = 3,
  parameter int WB_W  = 2,
  parameter int CNT_W = 8
);
  logic [EX_W-1:0]  id_ex_ctrl;
  logic [MEM_W-1:0] id_mem_ctrl;
  logic [WB_W-1:0]  id_wb_ctrl;
  logic             id_valid;
  logic             bubble;
  logic             flush;
  logic             freeze;

  logic [EX_W-1:0]  ex_ex_ctrl;
  logic [MEM_W-1:0] ex_mem_ctrl;
  logic [WB_W-1:0]  ex_wb_ctrl;
  logic             ex_valid;
  logic [MEM_W-1:0] mem_mem_ctrl;
  logic [WB_W-1:0]  mem_wb_ctrl;
  logic             mem_valid;
  logic [WB_W-1:0]  wb_wb_ctrl;
  logic             wb_valid;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Control/hazard side
  modport master (
    output id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_valid,
    output bubble, flush, freeze,
    input  ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl, ex_valid,
    input  mem_mem_ctrl, mem_wb_ctrl, mem_valid,
    input  wb_wb_ctrl, wb_valid,
    input  bubble_cnt, flush_cnt
  );

  // Pipeline register side
  modport slave (
    input  id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_valid,
    input  bubble, flush, freeze,
    output ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl, ex_valid,
    output mem_mem_ctrl, mem_wb_ctrl, mem_valid,
    output wb_wb_ctrl, wb_valid,
    output bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs
// Purpose: carries the decoded control bundle from ID through the EX, MEM
//   and WB stage registers, handling load-use bubbles, branch flushes and
//   global freeze, and keeps saturating bubble/flush counters for debug.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every stage and both counters
//   bus   : ctrl_pipe_regs_if slave modport (ID bundle and hazard requests
//           in, registered stage controls and counters out)
module ctrl_pipe_regs #(
  parameter int EX_W  = 4,
  parameter int MEM_W = 3,
  parameter int WB_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_pipe_regs_if.slave       bus
);

  logic [EX_W-1:0]  exExCtrl_q,   exExCtrl_d;
  logic [MEM_W-1:0] exMemCtrl_q,  exMemCtrl_d;
  logic [WB_W-1:0]  exWbCtrl_q,   exWbCtrl_d;
  logic             exValid_q,    exValid_d;
  logic [MEM_W-1:0] memMemCtrl_q, memMemCtrl_d;
  logic [WB_W-1:0]  memWbCtrl_q,  memWbCtrl_d;
  logic             memValid_q,   memValid_d;
  logic [WB_W-1:0]  wbWbCtrl_q,   wbWbCtrl_d;
  logic             wbValid_q,    wbValid_d;
  logic [CNT_W-1:0] bubbleCnt_q,  bubbleCnt_d;
  logic [CNT_W-1:0] flushCnt_q,   flushCnt_d;

  logic bubbleTaken;
  logic flushTaken;

  // Hazard priority: freeze masks everything, flush masks bubble.
  assign flushTaken  = !bus.freeze && bus.flush;
  assign bubbleTaken = !bus.freeze && !bus.flush && bus.bubble;

  // Next-state for all stage registers. Defaults hold the current value so
  // that freeze simply falls out of "nothing else assigned". Entries that
  // are not valid always carry zero controls, so the later stages can copy
  // fields without re-gating them.
  always_comb begin
    exExCtrl_d   = exExCtrl_q;
    exMemCtrl_d  = exMemCtrl_q;
    exWbCtrl_d   = exWbCtrl_q;
    exValid_d    = exValid_q;
    memMemCtrl_d = memMemCtrl_q;
    memWbCtrl_d  = memWbCtrl_q;
    memValid_d   = memValid_q;
    wbWbCtrl_d   = wbWbCtrl_q;
    wbValid_d    = wbValid_q;

    if (!bus.freeze) begin
      wbWbCtrl_d = memWbCtrl_q;
      wbValid_d  = memValid_q;

      if (flushTaken) begin
        memMemCtrl_d = '0;
        memWbCtrl_d  = '0;
        memValid_d   = 1'b0;
      end else begin
        memMemCtrl_d = exMemCtrl_q;
        memWbCtrl_d  = exWbCtrl_q;
        memValid_d   = exValid_q;
      end

      if (flushTaken || bubbleTaken || !bus.id_valid) begin
        exExCtrl_d  = '0;
        exMemCtrl_d = '0;
        exWbCtrl_d  = '0;
        exValid_d   = 1'b0;
      end else begin
        exExCtrl_d  = bus.id_ex_ctrl;
        exMemCtrl_d = bus.id_mem_ctrl;
        exWbCtrl_d  = bus.id_wb_ctrl;
        exValid_d   = 1'b1;
      end
    end
  end

  // Debug counters stick at all-ones instead of wrapping so that a long run
  // still reads as "at least this many".
  always_comb begin
    bubbleCnt_d = bubbleCnt_q;
    flushCnt_d  = flushCnt_q;
    if (bubbleTaken && (bubbleCnt_q != '1)) begin
      bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end
    if (flushTaken && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset wins over every hazard input and wipes any
  // in-flight entries at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      exExCtrl_q   <= '0;
      exMemCtrl_q  <= '0;
      exWbCtrl_q   <= '0;
      exValid_q    <= 1'b0;
      memMemCtrl_q <= '0;
      memWbCtrl_q  <= '0;
      memValid_q   <= 1'b0;
      wbWbCtrl_q   <= '0;
      wbValid_q    <= 1'b0;
      bubbleCnt_q  <= '0;
      flushCnt_q   <= '0;
    end else begin
      exExCtrl_q   <= exExCtrl_d;
      exMemCtrl_q  <= exMemCtrl_d;
      exWbCtrl_q   <= exWbCtrl_d;
      exValid_q    <= exValid_d;
      memMemCtrl_q <= memMemCtrl_d;
      memWbCtrl_q  <= memWbCtrl_d;
      memValid_q   <= memValid_d;
      wbWbCtrl_q   <= wbWbCtrl_d;
      wbValid_q    <= wbValid_d;
      bubbleCnt_q  <= bubbleCnt_d;
      flushCnt_q   <= flushCnt_d;
    end
  end

  // Outputs come straight from the registers.
  assign bus.ex_ex_ctrl   = exExCtrl_q;
  assign bus.ex_mem_ctrl  = exMemCtrl_q;
  assign bus.ex_wb_ctrl   = exWbCtrl_q;
  assign bus.ex_valid     = exValid_q;
  assign bus.mem_mem_ctrl = memMemCtrl_q;
  assign bus.mem_wb_ctrl  = memWbCtrl_q;
  assign bus.mem_valid    = memValid_q;
  assign bus.wb_wb_ctrl   = wbWbCtrl_q;
  assign bus.wb_valid     = wbValid_q;
  assign bus.bubble_cnt   = bubbleCnt_q;
  assign bus.flush_cnt    = flushCnt_q;

endmodule
